// File: rtl/drink_pkg.sv
// drink_pkg: definitions shared by the dispense controller, the vending FSM
// and their testbenches.
//   - beverage codes BEV_NONE / BEV_TEA / BEV_COFFEE
//   - default phase lengths, in clock cycles
//   - the controller state enum
//   - norm_bev(): folds the unused code 2'b11 onto BEV_NONE
// Optional feature macro: DRINK_CUP_DROP_EN adds the cup drop/wait states.
package drink_pkg;

    localparam logic [1:0] BEV_NONE   = 2'b00;
    localparam logic [1:0] BEV_TEA    = 2'b01;
    localparam logic [1:0] BEV_COFFEE = 2'b10;

    localparam int DEF_EJECT_CYCLES = 4;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_MIX_CYCLES   = 8;
    localparam int DEF_POUR_CYCLES  = 16;
    localparam int DEF_CNT_W        = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EJECT,
        ST_GAP,
        ST_DOSE,
        ST_POUR,
        ST_DONE,
        ST_FAULT
`ifdef DRINK_CUP_DROP_EN
        ,
        ST_CUP_DROP,
        ST_CUP_WAIT
`endif
    } state_e;

    // Code 2'b11 is not a beverage; it behaves exactly like "none".
    function automatic logic [1:0] norm_bev(input logic [1:0] bev);
        return (bev == 2'b11) ? BEV_NONE : bev;
    endfunction

endpackage

// File: rtl/drink_dispense_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that times one controller phase.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            load load_value this cycle (takes priority over counting)
//   load_value      cycles remaining minus one for the phase being entered
//   expired         high while the count is zero, i.e. last cycle of a phase
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Counts down to zero and parks there until the next load.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/drink_dispense_ctrl.sv
// drink_dispense_ctrl: actuator sequencer for one serve transaction.
// Accepts a beverage code plus a coin-change count, ejects the coins,
// runs the selected ingredient motor, opens the water valve, and reports
// busy/done/fault back to the vending FSM. All outputs are registered.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready serve request handshake
//   req_bev             00 none, 01 tea, 10 coffee, 11 treated as none
//   req_change          number of coins to eject, 0..3
//   water_ok            water level sensor, 1 = sufficient
//   coin_eject, motor_tea, motor_coffee, valve_water   actuators
//   busy, done, fault   status (done is a one-cycle pulse, fault is sticky)
//   cup_present/cup_drop  only with DRINK_CUP_DROP_EN defined
// Optional feature macro: DRINK_CUP_DROP_EN.
module drink_dispense_ctrl
    import drink_pkg::*;
#(
    parameter int EJECT_CYCLES = DEF_EJECT_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int MIX_CYCLES   = DEF_MIX_CYCLES,
    parameter int POUR_CYCLES  = DEF_POUR_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_bev,
    input  logic [1:0] req_change,
    input  logic       water_ok,
    output logic       coin_eject,
    output logic       motor_tea,
    output logic       motor_coffee,
    output logic       valve_water,
    output logic       busy,
    output logic       done,
`ifdef DRINK_CUP_DROP_EN
    input  logic       cup_present,
    output logic       cup_drop,
`endif
    output logic       fault
);

    // The timer counts down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] EJECT_LOAD = CNT_W'(EJECT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIX_LOAD   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] POUR_LOAD  = CNT_W'(POUR_CYCLES - 1);
`ifdef DRINK_CUP_DROP_EN
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'((2 ** CNT_W) - 2);
`endif

    state_e           state_q, state_d;
    state_e           dose_state;
    state_e           pre_dose_state;
    logic [1:0]       bev_q, bev_d;
    logic [1:0]       coins_q, coins_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_value;
    logic             tmr_expired;

    logic req_ready_q, req_ready_d;
    logic coin_eject_q, coin_eject_d;
    logic motor_tea_q, motor_tea_d;
    logic motor_coffee_q, motor_coffee_d;
    logic valve_water_q, valve_water_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic fault_q, fault_d;
`ifdef DRINK_CUP_DROP_EN
    logic cup_drop_q, cup_drop_d;
`endif

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .expired    (tmr_expired)
    );

    // Water is checked on the cycle that would enter DOSE; a dry reservoir
    // diverts straight to FAULT so no ingredient is wasted. With the cup
    // feature, the cup is dropped first and the check moves to the end of
    // the cup wait.
    always_comb begin
        dose_state = water_ok ? ST_DOSE : ST_FAULT;
`ifdef DRINK_CUP_DROP_EN
        pre_dose_state = ST_CUP_DROP;
`else
        pre_dose_state = dose_state;
`endif
    end

    // Next-state logic; every phase change reloads the shared timer.
    always_comb begin
        state_d        = state_q;
        bev_d          = bev_q;
        coins_d        = coins_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    bev_d   = norm_bev(req_bev);
                    coins_d = req_change;
                    if (req_change != 2'd0) begin
                        state_d        = ST_EJECT;
                        tmr_load       = 1'b1;
                        tmr_load_value = EJECT_LOAD;
                    end else if (norm_bev(req_bev) != BEV_NONE) begin
                        state_d        = pre_dose_state;
                        tmr_load       = 1'b1;
                        tmr_load_value = MIX_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EJECT: begin
                if (tmr_expired) begin
                    coins_d = coins_q - 2'd1;
                    if (coins_q > 2'd1) begin
                        state_d        = ST_GAP;
                        tmr_load       = 1'b1;
                        tmr_load_value = GAP_LOAD;
                    end else if (bev_q != BEV_NONE) begin
                        state_d        = pre_dose_state;
                        tmr_load       = 1'b1;
                        tmr_load_value = MIX_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_expired) begin
                    state_d        = ST_EJECT;
                    tmr_load       = 1'b1;
                    tmr_load_value = EJECT_LOAD;
                end
            end
            ST_DOSE: begin
                if (tmr_expired) begin
                    state_d        = ST_POUR;
                    tmr_load       = 1'b1;
                    tmr_load_value = POUR_LOAD;
                end
            end
            ST_POUR: begin
                if (!water_ok) begin
                    state_d = ST_FAULT;
                end else if (tmr_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`ifdef DRINK_CUP_DROP_EN
            ST_CUP_DROP: begin
                state_d        = ST_CUP_WAIT;
                tmr_load       = 1'b1;
                tmr_load_value = WAIT_LOAD;
            end
            ST_CUP_WAIT: begin
                if (cup_present) begin
                    state_d        = dose_state;
                    tmr_load       = 1'b1;
                    tmr_load_value = MIX_LOAD;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered copies
    // line up with the state they describe.
    always_comb begin
        req_ready_d    = (state_d == ST_IDLE);
        coin_eject_d   = (state_d == ST_EJECT);
        motor_tea_d    = (state_d == ST_DOSE) && (bev_d == BEV_TEA);
        motor_coffee_d = (state_d == ST_DOSE) && (bev_d == BEV_COFFEE);
        valve_water_d  = (state_d == ST_POUR);
        busy_d         = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        done_d         = (state_d == ST_DONE);
        fault_d        = (state_d == ST_FAULT);
`ifdef DRINK_CUP_DROP_EN
        cup_drop_d     = (state_d == ST_CUP_DROP);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bev_q          <= BEV_NONE;
            coins_q        <= 2'd0;
            req_ready_q    <= 1'b1;
            coin_eject_q   <= 1'b0;
            motor_tea_q    <= 1'b0;
            motor_coffee_q <= 1'b0;
            valve_water_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fault_q        <= 1'b0;
`ifdef DRINK_CUP_DROP_EN
            cup_drop_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            bev_q          <= bev_d;
            coins_q        <= coins_d;
            req_ready_q    <= req_ready_d;
            coin_eject_q   <= coin_eject_d;
            motor_tea_q    <= motor_tea_d;
            motor_coffee_q <= motor_coffee_d;
            valve_water_q  <= valve_water_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            fault_q        <= fault_d;
`ifdef DRINK_CUP_DROP_EN
            cup_drop_q     <= cup_drop_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign coin_eject   = coin_eject_q;
    assign motor_tea    = motor_tea_q;
    assign motor_coffee = motor_coffee_q;
    assign valve_water  = valve_water_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fault        = fault_q;
`ifdef DRINK_CUP_DROP_EN
    assign cup_drop     = cup_drop_q;
`endif

    // The actuators share one supply rail; never energise two at once.
    assert property (@(posedge clk) disable iff (rst)
        $onehot0({coin_eject_q, motor_tea_q, motor_coffee_q, valve_water_q}));

endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// tb_drink_dispense_ctrl: self-checking bench for drink_dispense_ctrl.
// The reference model expands each accepted request into a queue of
// per-cycle actuator activities (coins, gaps, motor, pour, done) and pops
// one entry per clock, applying the water rules on top. One compare task
// checks every DUT output against that model each cycle; a few literal
// cycle-indexed expectations pin both the model and the DUT.
module tb_drink_dispense_ctrl;

    localparam int E_CYC = 4;
    localparam int G_CYC = 2;
    localparam int M_CYC = 8;
    localparam int P_CYC = 16;

    // Output vector order: {req_ready, coin, tea, coffee, valve, busy, done, fault}
    localparam logic [7:0] V_IDLE  = 8'b1000_0000;
    localparam logic [7:0] V_GAP   = 8'b0000_0100;
    localparam logic [7:0] V_COIN  = 8'b0100_0100;
    localparam logic [7:0] V_TEA   = 8'b0010_0100;
    localparam logic [7:0] V_COF   = 8'b0001_0100;
    localparam logic [7:0] V_POUR  = 8'b0000_1100;
    localparam logic [7:0] V_DONE  = 8'b0000_0110;
    localparam logic [7:0] V_FAULT = 8'b0000_0001;

    typedef enum logic [2:0] {
        C_IDLE, C_GAP, C_COIN, C_TEA, C_COF, C_POUR, C_DONE, C_FAULT
    } code_t;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_bev;
    logic [1:0] req_change;
    logic       water_ok;
    logic       coin_eject;
    logic       motor_tea;
    logic       motor_coffee;
    logic       valve_water;
    logic       busy;
    logic       done;
    logic       fault;
`ifdef DRINK_CUP_DROP_EN
    logic       cup_present;
    logic       cup_drop;
`endif

    int    checks;
    int    errors;
    int    cycle;
    int    rel;
    code_t cur;
    code_t sched[$];

    drink_dispense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bev      (req_bev),
        .req_change   (req_change),
        .water_ok     (water_ok),
        .coin_eject   (coin_eject),
        .motor_tea    (motor_tea),
        .motor_coffee (motor_coffee),
        .valve_water  (valve_water),
        .busy         (busy),
        .done         (done),
`ifdef DRINK_CUP_DROP_EN
        .cup_present  (cup_present),
        .cup_drop     (cup_drop),
`endif
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector for a given activity.
    function automatic logic [7:0] codeVec(input code_t c);
        case (c)
            C_IDLE:  return V_IDLE;
            C_GAP:   return V_GAP;
            C_COIN:  return V_COIN;
            C_TEA:   return V_TEA;
            C_COF:   return V_COF;
            C_POUR:  return V_POUR;
            C_DONE:  return V_DONE;
            default: return V_FAULT;
        endcase
    endfunction

    function automatic logic [7:0] dutVec();
        return {req_ready, coin_eject, motor_tea, motor_coffee,
                valve_water, busy, done, fault};
    endfunction

    function automatic bit isMotor(input code_t c);
        return (c == C_TEA) || (c == C_COF);
    endfunction

    // Expand an accepted request into its per-cycle activity list.
    task automatic buildSchedule(input logic [1:0] bev, input logic [1:0] chg);
        sched.delete();
        for (int k = 0; k < int'(chg); k++) begin
            repeat (E_CYC) sched.push_back(C_COIN);
            if (k < int'(chg) - 1) repeat (G_CYC) sched.push_back(C_GAP);
        end
        if (bev == 2'b01 || bev == 2'b10) begin
            repeat (M_CYC) sched.push_back(bev == 2'b01 ? C_TEA : C_COF);
            repeat (P_CYC) sched.push_back(C_POUR);
        end
        sched.push_back(C_DONE);
    endtask

    // Take the next activity; the first motor cycle is refused if the
    // reservoir reads dry on the cycle before it.
    task automatic popNext(output code_t nxt);
        nxt = sched.pop_front();
        if (isMotor(nxt) && !isMotor(cur) && !water_ok) begin
            sched.delete();
            nxt = C_FAULT;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        code_t nxt;
        if (rst) begin
            sched.delete();
            nxt = C_IDLE;
        end else if (cur == C_FAULT) begin
            nxt = C_FAULT;
        end else if (cur == C_IDLE) begin
            if (req_valid) begin
                buildSchedule(req_bev, req_change);
                popNext(nxt);
            end else begin
                nxt = C_IDLE;
            end
        end else if (cur == C_POUR && !water_ok) begin
            sched.delete();
            nxt = C_FAULT;
        end else if (sched.size() == 0) begin
            nxt = C_IDLE;
        end else begin
            popNext(nxt);
        end
        cur = nxt;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic checkOutput();
        checks++;
        if (dutVec() !== codeVec(cur)) begin
            errors++;
            $display("[TB] FAIL outputs cycle %0d: got %b want %b (rdy,coin,tea,cof,valve,busy,done,fault)",
                     cycle, dutVec(), codeVec(cur));
        end
    endtask

    // Literal expectation: pins both the model and the DUT.
    task automatic pin(input string name, input logic [7:0] exp);
        checks++;
        if (codeVec(cur) !== exp) begin
            errors++;
            $display("[TB] FAIL model_%s rel %0d: got %b want %b", name, rel, codeVec(cur), exp);
        end
        checks++;
        if (dutVec() !== exp) begin
            errors++;
            $display("[TB] FAIL dut_%s rel %0d: got %b want %b", name, rel, dutVec(), exp);
        end
    endtask

    // One clock: model consumes current inputs, outputs sampled at negedge.
    task automatic tick();
        modelStep();
        @(negedge clk);
        cycle++;
        checkOutput();
    endtask

    task automatic advanceTo(input int target);
        while (rel < target) begin
            tick();
            rel++;
        end
    endtask

    // Present a request for exactly one edge; afterwards rel = 1.
    task automatic sendReq(input logic [1:0] bev, input logic [1:0] chg);
        req_valid  = 1'b1;
        req_bev    = bev;
        req_change = chg;
        rel = 0;
        tick();
        rel = 1;
        req_valid  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Random traffic: frequent requests, rare dry reservoir and resets,
    // and a reset soon after any fault so traffic keeps flowing.
    task automatic applyStimulus();
        if (cur == C_FAULT) rst = ($urandom_range(0, 9) == 0);
        else                rst = ($urandom_range(0, 399) == 0);
        req_valid  = ($urandom_range(0, 3) == 0);
        req_bev    = 2'($urandom_range(0, 3));
        req_change = 2'($urandom_range(0, 3));
        water_ok   = ($urandom_range(0, 99) != 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cycle      = 0;
        rel        = 0;
        cur        = C_IDLE;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_bev    = 2'b00;
        req_change = 2'd0;
        water_ok   = 1'b1;
`ifdef DRINK_CUP_DROP_EN
        cup_present = 1'b1;
`endif

        tick();
        pin("reset_state", V_IDLE);
        rst = 1'b0;
        tick();

        // Tea + 1 coin.
        sendReq(2'b01, 2'd1);
        pin("tea1_coin_first", V_COIN);
        advanceTo(4);  pin("tea1_coin_last", V_COIN);
        advanceTo(5);  pin("tea1_motor_first", V_TEA);
        advanceTo(12); pin("tea1_motor_last", V_TEA);
        advanceTo(13); pin("tea1_valve_first", V_POUR);
        advanceTo(28); pin("tea1_valve_last", V_POUR);
        advanceTo(29); pin("tea1_done", V_DONE);
        advanceTo(30); pin("tea1_ready", V_IDLE);

        // Coffee + 3 coins.
        sendReq(2'b10, 2'd3);
        advanceTo(4);  pin("cof3_coin1_last", V_COIN);
        advanceTo(5);  pin("cof3_gap1", V_GAP);
        advanceTo(7);  pin("cof3_coin2_first", V_COIN);
        advanceTo(13); pin("cof3_coin3_first", V_COIN);
        advanceTo(16); pin("cof3_coin3_last", V_COIN);
        advanceTo(17); pin("cof3_motor_first", V_COF);
        advanceTo(25); pin("cof3_valve_first", V_POUR);
        advanceTo(41); pin("cof3_done", V_DONE);
        advanceTo(42); pin("cof3_ready", V_IDLE);

        // No beverage, no change: done immediately.
        sendReq(2'b11, 2'd0);
        pin("bev11_done", V_DONE);
        advanceTo(2);
        sendReq(2'b00, 2'd0);
        pin("bev00_done", V_DONE);
        advanceTo(2);

        // Code 11 with change: coins only, no fault.
        sendReq(2'b11, 2'd2);
        advanceTo(5);  pin("bev11c2_gap", V_GAP);
        advanceTo(10); pin("bev11c2_coin_last", V_COIN);
        advanceTo(11); pin("bev11c2_done", V_DONE);
        advanceTo(12);

        // Water lost mid-pour: valve shuts next cycle, fault is sticky.
        sendReq(2'b01, 2'd1);
        advanceTo(20);
        water_ok = 1'b0;
        advanceTo(21); pin("pour_fault", V_FAULT);
        water_ok  = 1'b1;
        req_valid = 1'b1;
        advanceTo(25); pin("pour_fault_sticky", V_FAULT);
        req_valid = 1'b0;
        doReset();
        pin("pour_fault_cleared", V_IDLE);

        // Dry before dosing, no coins: straight to fault.
        water_ok = 1'b0;
        sendReq(2'b01, 2'd0);
        pin("predose_fault", V_FAULT);
        water_ok = 1'b1;
        doReset();

        // Dry at the end of the coin phase: coin done, then fault.
        sendReq(2'b10, 2'd1);
        advanceTo(4);
        water_ok = 1'b0;
        advanceTo(5); pin("postcoin_fault", V_FAULT);
        water_ok = 1'b1;
        doReset();

        // Change-only transaction ignores the water sensor.
        water_ok = 1'b0;
        sendReq(2'b00, 2'd1);
        advanceTo(5); pin("change_only_done", V_DONE);
        advanceTo(6);
        water_ok = 1'b1;

        // Reset in the middle of a transaction, then a normal request.
        sendReq(2'b10, 2'd2);
        advanceTo(6);
        rst = 1'b1;
        advanceTo(7); pin("midrst_idle", V_IDLE);
        rst = 1'b0;
        sendReq(2'b01, 2'd0);
        pin("after_rst_tea", V_TEA);
        advanceTo(25); pin("after_rst_done", V_DONE);
        advanceTo(26);

        // Randomized traffic against the model.
        repeat (4000) begin
            applyStimulus();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drink_dispense_ctrl.md
Name: drink_dispense_ctrl

Overview:
- Actuator-side end of the vending controller's serve/change outputs.
- Accepts one serve request per transaction: a beverage code plus a count of 5-unit coins to return.
- Sequences the coin ejector, the ingredient motors and the water valve with cycle-accurate timers.
- Reports busy/done/fault back to the vending FSM.

Parameters:
- EJECT_CYCLES, 4: cycles coin_eject is held high per coin
- GAP_CYCLES, 2: low cycles between consecutive coin ejects
- MIX_CYCLES, 8: cycles the ingredient motor is held high
- POUR_CYCLES, 16: cycles the water valve is held open
- CNT_W, 8: phase timer width; each *_CYCLES value must be in 1..2^CNT_W-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  serve request present
- req_ready  out  1  block can accept a request
- req_bev  in  2  00 none, 01 tea, 10 coffee, 11 treated as none
- req_change  in  2  coins to eject, 0..3
- water_ok  in  1  water level sensor, 1 = sufficient
- coin_eject  out  1  coin ejector solenoid
- motor_tea  out  1  tea hopper motor
- motor_coffee  out  1  coffee hopper motor
- valve_water  out  1  water valve
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- fault  out  1  sticky water fault

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1; all other outputs 0; state IDLE; timers and latches 0.
- rst mid-transaction aborts immediately; all actuators are low on the next cycle.
- Handshake: a transfer occurs on a clock edge with req_valid && req_ready. req_bev and req_change are latched on that edge.
- req_ready=1 only in IDLE with fault=0. req_valid while req_ready=0 is ignored; no queueing.
- busy=1 in every state except IDLE and FAULT.
- States and transitions:
  - IDLE: on transfer, go to EJECT if change>0; else DOSE if bev is tea or coffee; else DONE.
  - EJECT: coin_eject=1 for EJECT_CYCLES, then decrement the coin count. If count remains, go to GAP; else go to DOSE (or DONE if no beverage).
  - GAP: all actuators 0 for GAP_CYCLES, then return to EJECT. No gap follows the last coin.
  - DOSE: motor_tea or motor_coffee (only the selected one) =1 for MIX_CYCLES, then go to POUR.
  - POUR: valve_water=1 for POUR_CYCLES, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - FAULT: all actuators 0, fault=1, busy=0, req_ready=0. Exit only via rst.
- Water check:
  - water_ok is sampled on the cycle DOSE would be entered, and every POUR cycle.
  - water_ok=0 at either point goes to FAULT next cycle. The valve is closed the cycle after detection.
  - Coins already ejected are not reversed.
  - Change-only transactions never check water_ok.
- Timing: the first active output is asserted on the cycle after the transfer edge. Each phase holds its output exactly N cycles; phases are back-to-back with no idle cycle.
- Total latency, transfer to done: c·EJECT + max(c−1,0)·GAP + (bev ? MIX+POUR : 0) + 1 cycles, where c = coin count.
- req_bev=11 is silently treated as 00 and does not raise a fault.
- At most one actuator output is high in any cycle (assertion).

Optional Feature:
- Macro: DRINK_CUP_DROP_EN.
- Defined:
  - Adds input cup_present and output cup_drop.
  - Adds state CUP between EJECT/IDLE and DOSE: cup_drop=1 for 1 cycle, then waits for cup_present=1 up to 2^CNT_W−1 cycles.
  - Timeout goes to FAULT. Beverage-less transactions skip CUP.
- Undefined:
  - Ports and CUP state are absent; sequencing is exactly as above.

Decomposition:
- Package drink_pkg holds:
  - beverage code constants BEV_NONE/BEV_TEA/BEV_COFFEE
  - the state enum
  - default cycle-count constants, shared with the vending FSM and its testbench
- One sub-module, phase_timer: loadable down-counter with load/value/expired, instanced once and reloaded per phase.

Test Plan:
- Tea + 1 coin (defaults), transfer at cycle 0:
  - coin_eject high cycles 1–4
  - motor_tea high 5–12
  - valve_water high 13–28
  - done at 29, req_ready=1 at 30
- Coffee + 3 coins: coin_eject pulses at 1–4, 7–10, 13–16; motor_coffee 17–24; valve 25–40; done 41; motor_tea never high.
- bev=00/11 with change=0: done at cycle 1, no actuator ever high. bev=11 with change=2: two coin pulses, done at cycle 11.
- Water faults:
  - water_ok dropped at cycle 20 of a tea pour: valve low from 21, fault=1, req_ready stays 0 through new req_valid until rst.
  - water_ok=0 before dose: no motor pulse, goes straight to FAULT.
- rst asserted at cycle 6 of coffee + 2 coins: all outputs 0 at cycle 7, req_ready=1. A new request is accepted normally afterward.
- With DRINK_CUP_DROP_EN:
  - cup_present withheld: FAULT after 255 wait cycles.
  - cup_present at wait cycle 3: DOSE starts the following cycle.
